// File: rtl/dac_frame_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : dac_frame_scheduler_if
// Description : Valid/ready word channel between the frame scheduler and the
//               serial DAC shift-register module.
//                 dac_word  - sample word for the DAC shifter
//                 dac_ch    - channel index that dac_word belongs to
//                 dac_valid - dac_word/dac_ch are valid
//                 dac_ready - shifter accepts the word when high with dac_valid
//               master = scheduler side, slave = shifter side.
// Revision    : 1.0 - initial release
// ============================================================================
interface dac_frame_scheduler_if #(
  parameter int DW = 16
) ();
  logic [DW-1:0] dac_word;
  logic [2:0]    dac_ch;
  logic          dac_valid;
  logic          dac_ready;

  modport master (
    output dac_word,
    output dac_ch,
    output dac_valid,
    input  dac_ready
  );

  modport slave (
    input  dac_word,
    input  dac_ch,
    input  dac_valid,
    output dac_ready
  );
endinterface
`default_nettype wire

// File: rtl/dac_frame_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : dac_frame_scheduler
// Description : Builds a frame timebase from clk and, once per frame, issues
//               one 16-bit word per channel from an internal waveform table.
//               Channel n reads the table at sample_idx + n*phase_step
//               (modulo table depth) to steer the ultrasound beam.
// Ports       : clk, rst_n          - clock, asynchronous active-low reset
//               enable              - run frames while high
//               wr_en/wr_addr/wr_data - synchronous table write port
//               seq_len             - samples per period (0 or >depth = depth)
//               phase_step          - per-channel table address offset
//               mute                - (DAC_SCHED_MUTE_EN only) issue midscale
//               dac                 - valid/ready word channel (master)
//               frame_start         - one-cycle pulse at each frame boundary
//               busy                - frame in progress
//               sample_idx          - current waveform sample index
//               overrun             - sticky: frame boundary hit while busy
// Options     : `define DAC_SCHED_MUTE_EN adds the mute input.
// Revision    : 1.0 - initial release
// ============================================================================
module dac_frame_scheduler #(
  parameter int NUM_CH      = 2,
  parameter int DIV         = 6,
  parameter int FRAME_TICKS = 13,
  parameter int DW          = 16,
  parameter int AW          = 6
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  input  wire logic          enable,
  input  wire logic          wr_en,
  input  wire logic [AW-1:0] wr_addr,
  input  wire logic [DW-1:0] wr_data,
  input  wire logic [AW:0]   seq_len,
  input  wire logic [AW-1:0] phase_step,
`ifdef DAC_SCHED_MUTE_EN
  input  wire logic          mute,
`endif
  dac_frame_scheduler_if.master dac,
  output logic               frame_start,
  output logic               busy,
  output logic [AW-1:0]      sample_idx,
  output logic               overrun
);

  localparam int DEPTH = 2**AW;
  localparam int DCW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int TCW   = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;

  localparam logic [DCW-1:0] DIV_LAST  = DCW'(DIV - 1);
  localparam logic [TCW-1:0] TICK_LAST = TCW'(FRAME_TICKS - 1);
  localparam logic [2:0]     LAST_CH   = 3'(NUM_CH - 1);
  localparam logic [AW:0]    DEPTH_LEN = (AW+1)'(DEPTH);
  localparam logic [DW-1:0]  MIDSCALE  = {1'b1, {(DW-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RD    = 2'd1,
    S_ISSUE = 2'd2,
    S_NEXT  = 2'd3
  } state_t;

  // Waveform table (not reset; contents survive enable toggling).
  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  state_t        state_q, state_d;
  logic [DCW-1:0] div_cnt_q, div_cnt_d;
  logic [TCW-1:0] tick_cnt_q, tick_cnt_d;
  logic          frame_start_q, frame_start_d;
  logic [2:0]    ch_q, ch_d;
  logic          busy_q, busy_d;
  logic [AW-1:0] sample_idx_q, sample_idx_d;
  logic          overrun_q, overrun_d;
  logic [DW-1:0] dac_word_q, dac_word_d;
  logic          dac_valid_q, dac_valid_d;

  logic          mute_w;
  logic [AW+2:0] ch_offset_w;
  logic [AW-1:0] rd_addr_w;
  logic [DW-1:0] rd_data_w;
  logic [AW:0]   eff_len_w;
  logic [AW:0]   idx_inc_w;
  logic [AW-1:0] idx_next_w;

`ifdef DAC_SCHED_MUTE_EN
  assign mute_w = mute;
`else
  assign mute_w = 1'b0;
`endif

  // Channel offset wraps naturally by keeping only the low AW bits.
  assign ch_offset_w = {{AW{1'b0}}, ch_q} * {3'b000, phase_step};
  assign rd_addr_w   = sample_idx_q + ch_offset_w[AW-1:0];
  // The table read is combinational here but only ever lands in dac_word_q,
  // so a write on the same edge is seen by the next read, not this one.
  assign rd_data_w   = mem[rd_addr_w];

  assign eff_len_w  = ((seq_len == '0) || (seq_len > DEPTH_LEN)) ? DEPTH_LEN : seq_len;
  assign idx_inc_w  = {1'b0, sample_idx_q} + 1'b1;
  // ">=" rather than "==" so a shortened seq_len pulls an out-of-range index back to 0.
  assign idx_next_w = (idx_inc_w >= eff_len_w) ? '0 : idx_inc_w[AW-1:0];

  always_comb begin
    state_d       = state_q;
    div_cnt_d     = div_cnt_q;
    tick_cnt_d    = tick_cnt_q;
    frame_start_d = 1'b0;
    ch_d          = ch_q;
    busy_d        = busy_q;
    sample_idx_d  = sample_idx_q;
    overrun_d     = overrun_q;
    dac_word_d    = dac_word_q;
    dac_valid_d   = dac_valid_q;

    // Timebase: runs while enabled, holds while a frame drains after
    // enable drops, and clears once idle.
    if (enable) begin
      if (div_cnt_q == DIV_LAST) begin
        div_cnt_d = '0;
        if (tick_cnt_q == TICK_LAST) begin
          tick_cnt_d    = '0;
          frame_start_d = 1'b1;
        end else begin
          tick_cnt_d = tick_cnt_q + 1'b1;
        end
      end else begin
        div_cnt_d = div_cnt_q + 1'b1;
      end
    end else if (state_q == S_IDLE) begin
      div_cnt_d  = '0;
      tick_cnt_d = '0;
    end

    if (!enable) begin
      overrun_d = 1'b0;
    end else if (frame_start_q && busy_q) begin
      overrun_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (!enable) begin
          sample_idx_d = '0;
        end else if (frame_start_q) begin
          ch_d    = 3'd0;
          busy_d  = 1'b1;
          state_d = S_RD;
        end
      end
      S_RD: begin
        if (!enable) begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          dac_word_d  = mute_w ? MIDSCALE : rd_data_w;
          dac_valid_d = 1'b1;
          state_d     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // An issued word always finishes its handshake, even if enable drops.
        if (dac.dac_ready) begin
          dac_valid_d = 1'b0;
          state_d     = S_NEXT;
        end
      end
      S_NEXT: begin
        if (!enable) begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else if (ch_q == LAST_CH) begin
          sample_idx_d = idx_next_w;
          busy_d       = 1'b0;
          state_d      = S_IDLE;
        end else begin
          ch_d    = ch_q + 1'b1;
          state_d = S_RD;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      div_cnt_q     <= '0;
      tick_cnt_q    <= '0;
      frame_start_q <= 1'b0;
      ch_q          <= 3'd0;
      busy_q        <= 1'b0;
      sample_idx_q  <= '0;
      overrun_q     <= 1'b0;
      dac_word_q    <= '0;
      dac_valid_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      div_cnt_q     <= div_cnt_d;
      tick_cnt_q    <= tick_cnt_d;
      frame_start_q <= frame_start_d;
      ch_q          <= ch_d;
      busy_q        <= busy_d;
      sample_idx_q  <= sample_idx_d;
      overrun_q     <= overrun_d;
      dac_word_q    <= dac_word_d;
      dac_valid_q   <= dac_valid_d;
    end
  end

  assign dac.dac_word  = dac_word_q;
  assign dac.dac_ch    = ch_q;
  assign dac.dac_valid = dac_valid_q;
  assign frame_start   = frame_start_q;
  assign busy          = busy_q;
  assign sample_idx    = sample_idx_q;
  assign overrun       = overrun_q;

endmodule
`default_nettype wire
